// File: rtl/sumador_secuencial.sv
// Purpose: digit-serial N-bit adder/subtractor with carry, overflow, zero and negative flags.
// Latency: S = N/D cycles of CALC after the start edge; done pulses for one cycle after that.
// Backpressure: start is taken only in IDLE or DONE and is ignored (not queued) while busy.
module sumador_secuencial #(
    parameter int N = 4,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic         carry_in,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative,
    output logic         busy,
    output logic         done
);

    localparam int S  = N / D;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_params
        $error("sumador_secuencial: D must divide N and satisfy 1 <= D <= N");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    a_sr;
    logic [N-1:0]    b_sr;
    logic [N-1:0]    r_sr;
    logic            c;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            last;
    logic [D:0]      digit_sum;
    logic            c_msb;
    logic [N+D-1:0]  r_cat;
    logic [N-1:0]    r_next;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE accepts a new start so back-to-back runs skip IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Digit adder and partial-result shift; carry into the digit MSB is recovered from
    // sum ^ a ^ b so the same expression serves every digit width, including D = 1.
    always_comb begin
        accept    = start && (state != CALC);
        last      = (state == CALC) && (cnt == LAST);
        digit_sum = {1'b0, a_sr[D-1:0]} + {1'b0, b_sr[D-1:0]} + {{D{1'b0}}, c};
        c_msb     = digit_sum[D-1] ^ a_sr[D-1] ^ b_sr[D-1];
        r_cat     = {digit_sum[D-1:0], r_sr};
        r_next    = r_cat[N+D-1:D];
    end

    // Operand capture, digit-serial datapath, and result/flag update on the final digit only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (accept) begin
            a_sr <= A_num;
            b_sr <= op ? ~B_num : B_num;
            r_sr <= '0;
            c    <= op ? 1'b1 : carry_in;
            cnt  <= '0;
        end else if (state == CALC) begin
            a_sr <= a_sr >> D;
            b_sr <= b_sr >> D;
            r_sr <= r_next;
            c    <= digit_sum[D];
            cnt  <= cnt + 1'b1;
            if (last) begin
                result    <= r_next;
                carry_out <= digit_sum[D];
                overflow  <= c_msb ^ digit_sum[D];
                zero      <= (r_next == '0);
                negative  <= r_next[N-1];
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sumador_secuencial.sv
// Purpose: self-checking bench for sumador_secuencial with N=4/D=1 and N=8/D=2 instances.
// Latency: expects done S edges after the capture edge and busy for exactly S cycles.
// Backpressure: exercises start during CALC, start held in DONE, and reset mid-operation.
module tb_sumador_secuencial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       st4 = 1'b0, op4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] res4;
    logic       co4, ov4, z4, n4, busy4, done4;

    logic       st8 = 1'b0, op8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] res8;
    logic       co8, ov8, z8, n8, busy8, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sumador_secuencial #(.N(4), .D(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .op(op4), .A_num(a4), .B_num(b4),
        .carry_in(cin4), .result(res4), .carry_out(co4), .overflow(ov4), .zero(z4),
        .negative(n4), .busy(busy4), .done(done4)
    );

    sumador_secuencial #(.N(8), .D(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .op(op8), .A_num(a8), .B_num(b8),
        .carry_in(cin8), .result(res8), .carry_out(co8), .overflow(ov8), .zero(z8),
        .negative(n8), .busy(busy8), .done(done8)
    );

    wire [11:0] obs4 = {co4, ov4, z4, n4, 4'b0000, res4};
    wire [11:0] obs8 = {co8, ov8, z8, n8, res8};

    // Reference: plain integer arithmetic and signed range test, {co, ov, zero, neg, result}.
    function automatic logic [11:0] model(input int n, input logic o, input int a, input int b,
                                          input logic c);
        longint m, bi, full, res, sa, sb, sv;
        logic co, ov, zr, ng;
        logic [7:0] r8;
        m    = longint'(1) << n;
        bi   = o ? (m - 1 - b) : longint'(b);
        full = a + bi + (o ? 1 : int'(c));
        res  = full % m;
        co   = (full >= m);
        sa   = (a >= m / 2) ? a - m : longint'(a);
        sb   = (b >= m / 2) ? b - m : longint'(b);
        sv   = o ? (sa - sb) : (sa + sb + int'(c));
        ov   = (sv < -(m / 2)) || (sv >= m / 2);
        zr   = (res == 0);
        ng   = ((res >> (n - 1)) & 1) != 0;
        r8   = 8'(res);
        return {co, ov, zr, ng, r8};
    endfunction

    // Drive one operation on the selected DUT and wait (bounded) for its done pulse.
    task automatic exec(input bit sel, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int lat, output int bcnt, output logic [11:0] obs);
        @(negedge clk);
        if (sel) begin st8 = 1'b1; op8 = o; a8 = a; b8 = b; cin8 = c; end
        else begin st4 = 1'b1; op4 = o; a4 = a[3:0]; b4 = b[3:0]; cin4 = c; end
        lat = -1; bcnt = 0; obs = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                st4 = 1'b0; st8 = 1'b0;
                a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
                op4 = 1'($urandom); op8 = 1'($urandom);
            end
            if (sel ? busy8 : busy4) bcnt++;
            if (sel ? done8 : done4) begin
                lat = i;
                obs = sel ? obs8 : obs4;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int nd;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            st4 = 1'b1; st8 = 1'b1;
            a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            op4 = 1'($urandom); op8 = 1'($urandom); cin4 = 1'($urandom); cin8 = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({obs4, busy4, done4} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs4: got %h required 0", {obs4, busy4, done4});
        end
        checks++;
        if ({obs8, busy8, done8} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs8: got %h required 0", {obs8, busy8, done8});
        end
        st4 = 1'b0; st8 = 1'b0; rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4 || done8 || busy4 || busy8) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL reset_idle: got %0d busy/done cycles, required 0", nd);
        end
    endtask

    task automatic test_directed4();
        logic [11:0] obs, exp;
        int lat, bcnt;
        logic       o_t[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] a_t[6]   = '{8'd15, 8'd7, 8'd15, 8'd3, 8'd5, 8'd8};
        logic [7:0] b_t[6]   = '{8'd1, 8'd1, 8'd15, 8'd5, 8'd3, 8'd1};
        logic       c_t[6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [11:0] lit[6]  = '{12'b1010_0000_0000, 12'b0101_0000_1000, 12'b1001_0000_1111,
                                 12'b0001_0000_1110, 12'b1000_0000_0010, 12'b1100_0000_0111};
        for (int k = 0; k < 6; k++) begin
            exec(1'b0, o_t[k], a_t[k], b_t[k], c_t[k], lat, bcnt, obs);
            exp = model(4, o_t[k], int'(a_t[k]), int'(b_t[k]), c_t[k]);
            checks++;
            if (obs !== lit[k] || obs !== exp) begin
                errors++;
                $display("FAIL directed4[%0d]: got %h required %h (model %h)", k, obs, lit[k], exp);
            end
            checks++;
            if (lat !== 4 || bcnt !== 4) begin
                errors++;
                $display("FAIL timing4[%0d]: latency %0d busy %0d required 4/4", k, lat, bcnt);
            end
        end
    endtask

    task automatic test_directed8();
        logic [11:0] obs;
        int lat, bcnt;
        exec(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, lat, bcnt, obs);
        checks++;
        if (obs !== 12'b1010_0000_0000 || lat !== 4 || bcnt !== 4) begin
            errors++;
            $display("FAIL add8_ff_01: got %h lat %0d busy %0d required a00/4/4", obs, lat, bcnt);
        end
        exec(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0, lat, bcnt, obs);
        checks++;
        if (obs !== 12'b0101_1000_0000 || lat !== 4) begin
            errors++; $display("FAIL add8_7f_01: got %h lat %0d required 580/4", obs, lat);
        end
    endtask

    task automatic test_random();
        logic [11:0] obs, exp;
        int lat, bcnt;
        logic o, c;
        logic [7:0] a, b;
        for (int k = 0; k < 40; k++) begin
            bit sel = k[0];
            o = 1'($urandom); c = 1'($urandom);
            a = sel ? 8'($urandom) : 8'($urandom_range(15));
            b = sel ? 8'($urandom) : 8'($urandom_range(15));
            exec(sel, o, a, b, c, lat, bcnt, obs);
            exp = model(sel ? 8 : 4, o, int'(a), int'(b), c);
            checks++;
            if (obs !== exp || lat !== 4 || bcnt !== 4) begin
                errors++;
                $display("FAIL random[%0d] sel%0d op%0d %h %h c%0d: got %h lat %0d busy %0d required %h/4/4",
                         k, sel, o, a, b, c, obs, lat, bcnt, exp);
            end
        end
    endtask

    task automatic test_start_in_calc();
        int nd;
        logic [11:0] first, exp;
        exp = model(4, 1'b0, 6, 3, 1'b0);
        first = '0;
        @(negedge clk);
        st4 = 1'b1; op4 = 1'b0; a4 = 4'd6; b4 = 4'd3; cin4 = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) st4 = 1'b0;
            if (i == 1) begin st4 = 1'b1; op4 = 1'b1; a4 = 4'd1; b4 = 4'd9; end
            if (i == 2) st4 = 1'b0;
            if (done4) begin nd++; first = obs4; end
        end
        checks++;
        if (nd !== 1 || first !== exp) begin
            errors++; $display("FAIL start_in_calc: dones %0d result %h required 1/%h", nd, first, exp);
        end
        checks++;
        if (obs4 !== exp) begin
            errors++; $display("FAIL result_hold: got %h required %h", obs4, exp);
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        int idx[2];
        logic [11:0] r[2];
        logic [11:0] e0, e1;
        e0 = model(4, 1'b0, 2, 3, 1'b0);
        e1 = model(4, 1'b1, 9, 4, 1'b0);
        nd = 0; idx = '{-1, -1}; r = '{12'h0, 12'h0};
        @(negedge clk);
        st4 = 1'b1; op4 = 1'b0; a4 = 4'd2; b4 = 4'd3; cin4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin op4 = 1'b1; a4 = 4'd9; b4 = 4'd4; end
            if (done4 && nd < 2) begin
                idx[nd] = i; r[nd] = obs4; nd++;
                if (nd == 2) st4 = 1'b0;
            end
        end
        st4 = 1'b0;
        checks++;
        if (nd !== 2 || (idx[1] - idx[0]) !== 5) begin
            errors++; $display("FAIL b2b_spacing: dones %0d spacing %0d required 2/5", nd, idx[1] - idx[0]);
        end
        checks++;
        if (r[0] !== e0 || r[1] !== e1) begin
            errors++; $display("FAIL b2b_results: got %h %h required %h %h", r[0], r[1], e0, e1);
        end
    endtask

    task automatic test_reset_mid_calc();
        int nd;
        @(negedge clk);
        st4 = 1'b1; op4 = 1'b0; a4 = 4'd9; b4 = 4'd4; cin4 = 1'b0;
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({obs4, busy4, done4} !== 14'd0) begin
            errors++; $display("FAIL reset_mid_calc: got %h required 0", {obs4, busy4, done4});
        end
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL abandoned_op: got %0d busy/done cycles required 0", nd);
        end
    endtask

    initial begin
        test_reset();
        test_directed4();
        test_directed8();
        test_start_in_calc();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sumador_secuencial.md
# sumador_secuencial

Parametrised multi-cycle adder/subtractor, the sequential successor of the combinational N-bit ripple adder. It processes the operands D bits per cycle, least-significant digit first, through a start/busy/done handshake. On completion it reports carry/borrow and the signed overflow, zero and negative flags. It sits in the processor datapath as a shared-area arithmetic unit for wide operands, where a single-cycle N-bit carry chain is too costly.

## Interface
- N, 4, operand/result width in bits; N ≥ 1.
- D, 1, digit width processed per cycle; 1 ≤ D ≤ N, N % D == 0 (elaboration error otherwise).
- S (localparam) = N/D, number of digit cycles.

- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset is synchronous and active-low.
- start  input  1  request; sampled only when the unit is ready (IDLE or DONE).
- op  input  1  0 = add, 1 = subtract; captured with start.
- A_num  input  N  operand A; captured with start.
- B_num  input  N  operand B; captured with start.
- carry_in  input  1  carry-in for add; captured with start; ignored when op=1.
- result  output  N  final sum/difference; holds until the next completion.
- carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.
- negative  output  1  result[N-1].
- busy  output  1  high while state is CALC.
- done  output  1  single-cycle pulse; high exactly while state is DONE.

## Operation
- States: IDLE, CALC, DONE. Reset state: IDLE.
- IDLE or DONE with start=1:
  - Capture A into shift register a_sr.
  - Capture (op ? ~B_num : B_num) into b_sr.
  - Set running carry c = op ? 1 : carry_in.
  - Clear the digit counter cnt to 0.
  - Go to CALC.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- CALC, each cycle:
  - Compute {c', sum_d} = a_sr[D-1:0] + b_sr[D-1:0] + c, which is (D+1) bits wide.
  - Shift sum_d into the top of the partial-result register r_sr (right shift by D).
  - Shift a_sr and b_sr right by D.
  - Set c ← c' and increment cnt.
- CALC, on the digit where cnt == S-1:
  - Load result with the completed r_sr.
  - Load carry_out ← c'.
  - Load overflow ← (carry into bit N-1) XOR c'. When D=1 this is the previous c; when D>1 it is computed within the digit adder.
  - Load zero and negative from the final value.
  - Go to DONE.
- start is ignored while in CALC; it is neither queued nor treated as an error.
- result and the flags change only on the completing edge. Partial sums are never visible on the outputs.
- Arithmetic is modulo 2^N. Subtraction computes A + ~B + 1; carry_in has no effect when op=1.

## Timing
- Reset values: result = 0, carry_out = 0, overflow = 0, zero = 0, negative = 0, busy = 0, done = 0. Internal registers and cnt are cleared.
- Latency: start sampled at edge k. busy is high in the cycles after edges k … k+S-1. done is high in the cycle after edge k+S, and the outputs are valid from that same cycle.
- Throughput:
  - Back-to-back operation with start held: one result every S+1 cycles, since start is accepted in DONE.
  - Isolated operations (start low in DONE): one result every S+2 cycles, because of the IDLE cycle.
- Reset (rst_n=0 at any edge, including mid-CALC or in DONE): the operation is abandoned, no done pulse follows, and all outputs return to their reset values on that edge.
- Operands may change freely after the capture edge; this does not affect the operation in flight.
- When rst_n=0 and start=1 on the same edge, reset wins and start is not captured.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0 and busy=0. Release -> no done pulse without start.
- N=4, D=1, add 15+1, carry_in=0 -> done exactly 4 cycles after start. result=0000, carry_out=1, zero=1, overflow=0, negative=0. busy high for exactly 4 cycles.
- N=4, D=1 add cases:
  - 7+1 -> result=1000, overflow=1, negative=1, carry_out=0.
  - 15+15, carry_in=1 -> result=1111, carry_out=1, overflow=0.
- N=4, D=1 subtract cases:
  - 3-5 with carry_in=1 (ignored) -> result=1110, carry_out=0, negative=1, overflow=0.
  - 5-3 -> result=0010, carry_out=1.
  - 8-1 -> result=0111, overflow=1.
- Handshake checks:
  - Pulse start during CALC -> ignored, single done, result unchanged.
  - Start asserted in the DONE cycle -> accepted, next done 5 cycles after the previous one.
  - rst_n=0 in the 2nd CALC cycle -> no done, outputs 0.
- N=8, D=2: 0xFF+0x01 -> done 4 cycles after start, result=0x00, carry_out=1, zero=1. 0x7F+0x01 -> result=0x80, overflow=1.
